// File: rtl/ov_fifo_reader.sv
// Read side of the camera frame buffer: drains one frame from an AL422B-style FIFO onto a byte stream.
// Optional 4-byte frame header (FF 00 FF AA) ahead of the pixels when OV_FRAME_HEADER_EN is defined.
module ov_fifo_reader #(
    parameter int FRAME_BYTES = 614400,
    parameter int RCLK_DIV    = 4,
    parameter int RRST_CLKS   = 2
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic [7:0] fifo_data,
    output logic       rclk,
    output logic       rrst,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_read,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for new_frame
    // PRST  | rrst low, RRST_CLKS rclk pulses rewind the FIFO read pointer
    // HDR   | header bytes on the stream, rclk held low (header builds only)
    // RD_HI | rclk high phase; the FIFO byte is captured on its last cycle
    // WAIT  | byte offered on the stream, rclk low until it is accepted
    // RD_LO | remainder of the rclk low phase before the next read
    // DONE  | one-cycle frame_read pulse

    localparam int CNT_W  = $clog2(FRAME_BYTES + 1);
    localparam int TMR_W  = (RCLK_DIV > 2) ? $clog2(RCLK_DIV) : 1;
    localparam int RISE_W = (RRST_CLKS > 1) ? $clog2(RRST_CLKS + 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [TMR_W-1:0]  PHASE_END = TMR_W'(RCLK_DIV - 1);
    localparam logic [TMR_W-1:0]  LO_END    = TMR_W'(RCLK_DIV - 2);
    localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(RRST_CLKS);

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        RD_HI,
        WAIT,
        RD_LO,
`ifdef OV_FRAME_HEADER_EN
        HDR,
`endif
        DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    byte_cnt;
    logic [TMR_W-1:0]    timer;
    logic [RISE_W-1:0]   rise_cnt;

`ifdef OV_FRAME_HEADER_EN
    logic [1:0] hdr_idx;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'hFF;
            2'd1:    b = 8'h00;
            2'd2:    b = 8'hFF;
            default: b = 8'hAA;
        endcase
        return b;
    endfunction
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            timer      <= '0;
            rise_cnt   <= '0;
            rclk       <= 1'b0;
            rrst       <= 1'b1;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            frame_read <= 1'b0;
            busy       <= 1'b0;
`ifdef OV_FRAME_HEADER_EN
            hdr_idx    <= 2'd0;
`endif
        end else begin
            frame_read <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_frame) begin
                        state    <= PRST;
                        byte_cnt <= '0;
                        timer    <= '0;
                        rise_cnt <= '0;
                        rclk     <= 1'b0;
                        rrst     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                PRST: begin
                    // One rrst setup cycle with rclk low precedes the first rising edge.
                    if (!rclk && rise_cnt == '0) begin
                        rclk     <= 1'b1;
                        rise_cnt <= RISE_W'(1);
                        timer    <= '0;
                    end else if (timer == PHASE_END) begin
                        timer <= '0;
                        if (rclk) begin
                            rclk <= 1'b0;
                        end else if (rise_cnt == RISE_LAST) begin
                            rrst <= 1'b1;
`ifdef OV_FRAME_HEADER_EN
                            state     <= HDR;
                            hdr_idx   <= 2'd0;
                            out_data  <= hdr_byte(2'd0);
                            out_valid <= 1'b1;
`else
                            rclk  <= 1'b1;
                            state <= RD_HI;
`endif
                        end else begin
                            rclk     <= 1'b1;
                            rise_cnt <= rise_cnt + RISE_W'(1);
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

`ifdef OV_FRAME_HEADER_EN
                HDR: begin
                    if (out_valid && out_ready) begin
                        if (hdr_idx == 2'd3) begin
                            // RD_LO stretches the rclk low time before the first pixel read.
                            out_valid <= 1'b0;
                            timer     <= '0;
                            state     <= RD_LO;
                        end else begin
                            hdr_idx  <= hdr_idx + 2'd1;
                            out_data <= hdr_byte(hdr_idx + 2'd1);
                        end
                    end
                end
`endif

                RD_HI: begin
                    if (timer == PHASE_END) begin
                        timer     <= '0;
                        rclk      <= 1'b0;
                        out_data  <= fifo_data;
                        out_valid <= 1'b1;
                        state     <= WAIT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                WAIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        byte_cnt  <= byte_cnt + CNT_W'(1);
                        timer     <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            frame_read <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= RD_LO;
                        end
                    end
                end

                RD_LO: begin
                    // The accept cycle in WAIT already counted as one low cycle.
                    if (timer == LO_END) begin
                        timer <= '0;
                        rclk  <= 1'b1;
                        state <= RD_HI;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Bench for ov_fifo_reader: FIFO behavioural model, randomized ready/data, stream compared to a queue model.
// Header expectations follow OV_FRAME_HEADER_EN.
module tb_ov_fifo_reader;

    localparam int FB = 4;
    localparam int D  = 2;
    localparam int R  = 2;
`ifdef OV_FRAME_HEADER_EN
    localparam int HDR_N = 4;
    localparam int LAT   = 2 * D * R + 2;
`else
    localparam int HDR_N = 0;
    localparam int LAT   = 2 * D * R + D + 2;
`endif

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_frame = 1'b0, new_frame_m = 1'b0;
    logic [7:0] fifo_data = 8'h00, fifo_data_m = 8'h00;
    logic       rclk, rrst, out_valid, frame_read, busy;
    logic       rclk_m, rrst_m, out_valid_m, frame_read_m, busy_m;
    logic [7:0] out_data, out_data_m;
    logic       out_ready = 1'b0, out_ready_m = 1'b1;

    ov_fifo_reader #(.FRAME_BYTES(FB), .RCLK_DIV(D), .RRST_CLKS(R)) dut (
        .sys_clk(sys_clk), .rst(rst), .new_frame(new_frame), .fifo_data(fifo_data),
        .rclk(rclk), .rrst(rrst), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .frame_read(frame_read), .busy(busy)
    );

    ov_fifo_reader #(.FRAME_BYTES(1), .RCLK_DIV(D), .RRST_CLKS(R)) dut_min (
        .sys_clk(sys_clk), .rst(rst), .new_frame(new_frame_m), .fifo_data(fifo_data_m),
        .rclk(rclk_m), .rrst(rrst_m), .out_data(out_data_m), .out_valid(out_valid_m),
        .out_ready(out_ready_m), .frame_read(frame_read_m), .busy(busy_m)
    );

    always #5 sys_clk = ~sys_clk;

    // FIFO models: a rising rclk with rrst low rewinds, otherwise presents the next byte.
    logic [7:0] mem [FB];
    logic [7:0] mem_m = 8'h00;
    int         ptr = 0, ptr_m = 0;
    logic       prev_rclk = 1'b0, prev_rclk_m = 1'b0;

    always @(negedge sys_clk) begin
        if (rclk && !prev_rclk) begin
            if (!rrst) ptr = 0;
            else begin
                fifo_data = (ptr < FB) ? mem[ptr] : 8'hEE;
                ptr++;
            end
        end
        prev_rclk = rclk;
        if (rclk_m && !prev_rclk_m) begin
            if (!rrst_m) ptr_m = 0;
            else begin
                fifo_data_m = (ptr_m == 0) ? mem_m : 8'hEE;
                ptr_m++;
            end
        end
        prev_rclk_m = rclk_m;
    end

    int compared = 0, mismatched = 0;
    logic [7:0] got[$], exp_q[$];
    logic [7:0] hdr_bytes [4] = '{8'hFF, 8'h00, 8'hFF, 8'hAA};
    int rises, rrst_rises, fr_cnt, first_valid, stall_err, busy_err;
    bit timed_out, rst_hit;

    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < HDR_N; i++) exp_q.push_back(hdr_bytes[i]);
        for (int i = 0; i < FB; i++) exp_q.push_back(mem[i]);
    endtask

    // Runs one frame on the main instance and records what the stream and FIFO pins did.
    task automatic run_frame(input int ready_pct, input int stall_at, input int stall_len,
                             input int drop_at, input int rst_at);
        logic pv, pr, prclk;
        logic [7:0] pd;
        int stall_left, fr_at;
        bit drop_clr, rst_pend;
        got.delete();
        rises = 0; rrst_rises = 0; fr_cnt = 0; first_valid = -1; stall_err = 0; busy_err = 0;
        timed_out = 1; rst_hit = 0;
        pv = 0; pr = 0; pd = 0; stall_left = stall_len; fr_at = -1; drop_clr = 0; rst_pend = 0;
        @(negedge sys_clk);
        new_frame = 1'b1;
        prclk = rclk;
        for (int cyc = 1; cyc < 4000; cyc++) begin
            @(negedge sys_clk);
            if (cyc == 1 || drop_clr) begin new_frame = 1'b0; drop_clr = 0; end
            if (rst_pend) begin rst = 1'b1; #1; rst_hit = 1; timed_out = 0; break; end
            if (cyc == 1 && busy !== 1'b1) busy_err++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (rclk && !prclk) begin rises++; if (!rrst) rrst_rises++; end
            prclk = rclk;
            if (out_valid && rclk) stall_err++;
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) stall_err++;
            if (frame_read) begin fr_cnt++; if (fr_at < 0) fr_at = cyc; end
            if (fr_at >= 0 && cyc == fr_at + 1) begin
                if (busy !== 1'b0) busy_err++;
                timed_out = 0;
                break;
            end
            if (stall_at >= 0 && got.size() == stall_at && out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (got.size() == drop_at) begin new_frame = 1'b1; drop_clr = 1; end
                if (got.size() == rst_at) rst_pend = 1;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        compared++;
        if ({rclk, rrst, out_data, out_valid, frame_read, busy} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_outputs got rclk=%b rrst=%b data=%h valid=%b fr=%b busy=%b want 0 1 00 0 0 0",
                     rclk, rrst, out_data, out_valid, frame_read, busy);
        end
        compared++;
        if ({rclk_m, rrst_m, out_valid_m, busy_m} !== 4'b0100) begin
            mismatched++;
            $display("FAIL reset_min got %b want 0100", {rclk_m, rrst_m, out_valid_m, busy_m});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mem = '{8'h11, 8'h22, 8'h33, 8'h44};
        build_exp();
        run_frame(100, -1, 0, -1, -1);
        compared++; if (timed_out) begin mismatched++; $display("FAIL basic_done got=timeout want=frame_read"); end
        compared++; if (rrst_rises != R) begin mismatched++; $display("FAIL basic_rrst_rises got=%0d want=%0d", rrst_rises, R); end
        compared++; if (rises != R + FB) begin mismatched++; $display("FAIL basic_rises got=%0d want=%0d", rises, R + FB); end
        compared++; if (first_valid != LAT) begin mismatched++; $display("FAIL basic_latency got=%0d want=%0d", first_valid, LAT); end
        compared++; if (got.size() != exp_q.size()) begin mismatched++; $display("FAIL basic_len got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL basic_byte%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'h00, exp_q[i]);
            end
        end
        compared++; if (fr_cnt != 1) begin mismatched++; $display("FAIL basic_frame_read got=%0d want=1", fr_cnt); end
        compared++; if (busy_err != 0) begin mismatched++; $display("FAIL basic_busy got=%0d errors want=0", busy_err); end
    endtask

    task automatic test_backpressure();
        mem = '{8'h11, 8'h22, 8'h33, 8'h44};
        build_exp();
        run_frame(100, HDR_N + 1, 10, -1, -1);
        compared++; if (timed_out) begin mismatched++; $display("FAIL bp_done got=timeout want=frame_read"); end
        compared++; if (stall_err != 0) begin mismatched++; $display("FAIL bp_hold got=%0d errors want=0", stall_err); end
        compared++; if (rises != R + FB) begin mismatched++; $display("FAIL bp_rises got=%0d want=%0d", rises, R + FB); end
        compared++;
        if (got.size() != exp_q.size() || got[HDR_N + 1] !== 8'h22 || got[HDR_N + 3] !== 8'h44) begin
            mismatched++;
            $display("FAIL bp_stream got len=%0d want len=%0d with 22 then 44", got.size(), exp_q.size());
        end
    endtask

    task automatic test_dropped();
        int extra;
        mem = '{8'h5C, 8'h6D, 8'h7E, 8'h8F};
        build_exp();
        run_frame(100, -1, 0, HDR_N + 1, -1);
        compared++; if (got != exp_q) begin mismatched++; $display("FAIL drop_stream got len=%0d want len=%0d", got.size(), exp_q.size()); end
        compared++; if (fr_cnt != 1) begin mismatched++; $display("FAIL drop_frame_read got=%0d want=1", fr_cnt); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (out_valid || busy || frame_read) extra++;
        end
        compared++; if (extra != 0) begin mismatched++; $display("FAIL drop_idle got=%0d active cycles want=0", extra); end
    endtask

    task automatic test_reset_mid();
        mem = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(100, -1, 0, -1, HDR_N + 2);
        compared++; if (!rst_hit) begin mismatched++; $display("FAIL rstmid_reached got=no want=yes"); end
        compared++;
        if ({rclk, rrst, out_data, out_valid, frame_read, busy} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL rstmid_async got rclk=%b rrst=%b data=%h valid=%b fr=%b busy=%b want 0 1 00 0 0 0",
                     rclk, rrst, out_data, out_valid, frame_read, busy);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
        build_exp();
        run_frame(100, -1, 0, -1, -1);
        compared++; if (rrst_rises != R) begin mismatched++; $display("FAIL rstmid_prst got=%0d want=%0d", rrst_rises, R); end
        compared++; if (got != exp_q) begin mismatched++; $display("FAIL rstmid_stream got len=%0d want len=%0d", got.size(), exp_q.size()); end
        compared++; if (fr_cnt != 1) begin mismatched++; $display("FAIL rstmid_frame_read got=%0d want=1", fr_cnt); end
    endtask

    task automatic test_random();
        int pct;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
            build_exp();
            pct = $urandom_range(100, 25);
            run_frame(pct, -1, 0, -1, -1);
            compared++;
            if (timed_out || got != exp_q || fr_cnt != 1 || rises != R + FB || stall_err != 0 || busy_err != 0) begin
                mismatched++;
                $display("FAIL rand_frame%0d got len=%0d fr=%0d rises=%0d stall=%0d busy=%0d to=%0d want len=%0d fr=1 rises=%0d 0 0 0",
                         f, got.size(), fr_cnt, rises, stall_err, busy_err, timed_out, exp_q.size(), R + FB);
            end
        end
    endtask

    task automatic test_min_frame();
        logic [7:0] gm[$], em[$];
        logic pr;
        int rm, fm;
        for (int f = 0; f < 2; f++) begin
            mem_m = (f == 0) ? 8'hA5 : 8'h5A;
            em.delete();
            for (int i = 0; i < HDR_N; i++) em.push_back(hdr_bytes[i]);
            em.push_back(mem_m);
            gm.delete(); rm = 0; fm = 0;
            @(negedge sys_clk);
            new_frame_m = 1'b1;
            pr = rclk_m;
            for (int cyc = 1; cyc < 60; cyc++) begin
                @(negedge sys_clk);
                new_frame_m = 1'b0;
                if (rclk_m && !pr) rm++;
                pr = rclk_m;
                if (frame_read_m) fm++;
                if (out_valid_m && out_ready_m) gm.push_back(out_data_m);
            end
            compared++; if (gm != em) begin mismatched++; $display("FAIL min_stream%0d got len=%0d last=%h want len=%0d last=%h", f, gm.size(), (gm.size() > 0) ? gm[gm.size()-1] : 8'h00, em.size(), mem_m); end
            compared++; if (fm != 1) begin mismatched++; $display("FAIL min_frame_read%0d got=%0d want=1", f, fm); end
            compared++; if (rm != R + 1) begin mismatched++; $display("FAIL min_rises%0d got=%0d want=%0d", f, rm, R + 1); end
            compared++; if (busy_m !== 1'b0) begin mismatched++; $display("FAIL min_idle%0d got busy=%b want 0", f, busy_m); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_dropped();
        test_reset_mid();
        test_random();
        test_min_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ov_fifo_reader.md
Name: ov_fifo_reader

Overview:
- Read side of the camera frame buffer. It drains one complete frame from the AL422B-style FIFO that the store path fills, and presents the bytes one at a time on a valid/ready stream.
- The stream feeds the UART TX path, which takes one byte per handshake.
- It also drives the FIFO read clock and the active-low read-pointer reset.
- It pulses frame_read when the frame is consumed, so the store path can capture the next frame.

Parameters:
- FRAME_BYTES, 614400: bytes per frame (640x480, 2 B/pixel); must be at least 1.
- RCLK_DIV, 4: sys_clk cycles per rclk phase (high and low phases are equal); must be at least 2.
- RRST_CLKS, 2: number of rclk rising edges issued with rrst low during the pointer reset.

Ports:
- sys_clk  in  1  block clock.
- rst  in  1  asynchronous reset, active-high.
- new_frame  in  1  one-cycle pulse: a frame is complete in the FIFO.
- fifo_data  in  8  FIFO read data.
- rclk  out  1  FIFO read clock.
- rrst  out  1  FIFO read-pointer reset, active-low.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte.
- frame_read  out  1  one-cycle pulse after the last byte of a frame is accepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: rclk=0, rrst=1, out_data=0, out_valid=0, frame_read=0, busy=0, state=IDLE, byte counter=0.
- Reset asserted mid-frame: everything returns to the reset values on the same edge. The FIFO pointer is not rewound until the next new_frame.
- All outputs are registered.
- Phase timer counts 0..RCLK_DIV-1 and is cleared on every phase change.

State machine:
- IDLE:
  - On new_frame=1, go to PRST and clear the byte counter. busy rises on the next cycle.
  - new_frame seen in any other state is ignored (dropped, not queued).
- PRST:
  - rrst=0. rclk toggles with RCLK_DIV-cycle phases until RRST_CLKS rising edges have been issued.
  - After the final low phase, set rrst=1 and go to RD_HI.
  - No data is captured in this state.
- RD_HI:
  - rclk=1 for RCLK_DIV cycles; the rising edge outputs the next FIFO byte.
  - On the last cycle of the phase, register fifo_data into out_data and set out_valid=1. Then set rclk=0 and go to WAIT.
- WAIT:
  - rclk held at 0.
  - When out_valid & out_ready, the byte is accepted on that edge: out_valid=0, byte counter +1.
    - If the counter equals FRAME_BYTES-1, go to DONE.
    - Otherwise go to RD_LO.
  - Any stall length is allowed. rclk stays low while stalled, so the FIFO pointer does not advance.
- RD_LO:
  - rclk=0 for RCLK_DIV-1 further cycles (the accept cycle counts as one), so the low phase is at least RCLK_DIV cycles. Then go to RD_HI.
- DONE:
  - frame_read=1 for exactly one cycle, then go to IDLE.

Stream and counting rules:
- out_data is stable while out_valid=1.
- out_valid never drops without a handshake.
- Stream latency: first out_valid occurs 2*RCLK_DIV*RRST_CLKS + RCLK_DIV + 1 cycles after new_frame, plus 1 cycle for registering.
- Byte counter width is clog2(FRAME_BYTES+1) and it never wraps; exactly FRAME_BYTES bytes are emitted per frame.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro OV_FRAME_HEADER_EN.
- Defined:
  - After PRST and before the first FIFO byte, the block emits 4 header bytes 0xFF, 0x00, 0xFF, 0xAA on the stream with the same handshake.
  - rclk stays low during the header.
  - The header is not counted in FRAME_BYTES, and frame_read timing relative to the last pixel byte is unchanged.
- Not defined:
  - The stream carries pixel bytes only and the header logic is absent.

Test Plan (FRAME_BYTES=4, RCLK_DIV=2, RRST_CLKS=2 unless stated):
- Basic frame:
  - Stimulus: FIFO model returns 0x11, 0x22, 0x33, 0x44; out_ready tied high; pulse new_frame.
  - Required: rrst low across exactly 2 rclk rises; stream 0x11, 0x22, 0x33, 0x44; one frame_read pulse; busy falls the cycle after it.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles at byte 2.
  - Required: out_valid=1 and out_data=0x22 held stable; rclk stays 0 with no extra rising edges; total rclk rises = 2+4.
- Dropped request:
  - Stimulus: a second new_frame pulse at byte 1.
  - Required: ignored; exactly 4 bytes and 1 frame_read; block returns to IDLE.
- Reset mid-frame:
  - Stimulus: assert rst after byte 2 is accepted.
  - Required: all outputs at reset values immediately (asynchronous); a following new_frame yields a full 4-byte frame starting with a fresh PRST.
- Minimum frame:
  - Stimulus: FRAME_BYTES=1, fifo_data=0xA5.
  - Required: single byte 0xA5 then frame_read; counter width 1 bit with no overflow.
- OV_FRAME_HEADER_EN defined:
  - Required: stream is FF 00 FF AA 11 22 33 44; 6 rclk rises total; frame_read after 0x44 only.
